obi_rready_converter: RTL and testbench

//  Bridges an OBI manager that uses rready (ObiCfg.UseRReady=1) to a subordinate without

---
 rtl/obi_pkg.sv | 23 ++
 rtl/obi_rsp_fifo.sv | 69 ++++++
 rtl/obi_rready_converter.sv | 113 +++++++++++
 tb/tb_obi_rready_converter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared OBI bus configuration and sizing helpers.
package obi_pkg;

    typedef struct packed {
        bit          UseRReady;
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        UseRReady: 1'b1,
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   1
    };

    // One R-channel beat: rdata, rid and the err flag.
    function automatic int unsigned obi_r_chan_width(input obi_cfg_t cfg);
        return cfg.DataWidth + cfg.IdWidth + 1;
    endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// Fall-through response FIFO: when empty, the incoming beat is presented on the
// same cycle and only stored if the consumer does not take it.
module obi_rsp_fifo #(
    parameter int          Depth = 2,
    parameter int unsigned Width = 34
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [Width-1:0] data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic [CntW-1:0]  occ;
    logic             wr_en;
    logic             rd_en;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (occ == '0);
    assign full  = (occ == CntW'(Depth));
    assign valid = !empty || push;
    assign data  = empty ? push_data : mem[rd_ptr];
    assign wr_en = push && !(empty && pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && full && !rd_en));

endmodule

// File: rtl/obi_rready_converter.sv
// Adapts an rready-capable OBI manager to a subordinate that cannot stall its
// responses; a credit counter limits outstanding requests to the buffer depth.
module obi_rready_converter
    import obi_pkg::*;
#(
    parameter obi_cfg_t ObiCfg = ObiDefaultConfig,
    parameter int       Depth  = 2,
    localparam int unsigned AW  = ObiCfg.AddrWidth,
    localparam int unsigned DW  = ObiCfg.DataWidth,
    localparam int unsigned IdW = (ObiCfg.IdWidth == 0) ? 1 : ObiCfg.IdWidth
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           mgr_req_i,
    output logic           mgr_gnt_o,
    input  logic [AW-1:0]  mgr_addr_i,
    input  logic           mgr_we_i,
    input  logic [DW/8-1:0] mgr_be_i,
    input  logic [DW-1:0]  mgr_wdata_i,
    input  logic [IdW-1:0] mgr_aid_i,
    output logic           mgr_rvalid_o,
    input  logic           mgr_rready_i,
    output logic [DW-1:0]  mgr_rdata_o,
    output logic [IdW-1:0] mgr_rid_o,
    output logic           mgr_err_o,
    output logic           sbr_req_o,
    input  logic           sbr_gnt_i,
    output logic [AW-1:0]  sbr_addr_o,
    output logic           sbr_we_o,
    output logic [DW/8-1:0] sbr_be_o,
    output logic [DW-1:0]  sbr_wdata_o,
    output logic [IdW-1:0] sbr_aid_o,
    input  logic           sbr_rvalid_i,
    input  logic [DW-1:0]  sbr_rdata_i,
    input  logic [IdW-1:0] sbr_rid_i,
    input  logic           sbr_err_i
);

    // A zero-width id still occupies one (always zero) bit in the stored beat.
    localparam int unsigned FifoW = obi_r_chan_width(ObiCfg) + ((ObiCfg.IdWidth == 0) ? 1 : 0);
    localparam int unsigned CntW  = (Depth > 0) ? $clog2(Depth + 1) : 1;

    if (Depth < 1) begin : g_bad_depth
        $fatal(1, "obi_rready_converter: Depth must be at least 1");
    end

    if (!ObiCfg.UseRReady) begin : g_bad_cfg
        $fatal(1, "obi_rready_converter: manager side must use rready");
    end

    logic [CntW-1:0]  cnt;
    logic             space;
    logic             inc;
    logic             dec;
    logic [IdW-1:0]   rid_in;
    logic [FifoW-1:0] rsp_in;
    logic [FifoW-1:0] rsp_out;
    logic             fifo_full;
    logic             fifo_empty;

    // Space depends only on registered state, so rready never reaches gnt combinationally.
    assign space     = (cnt < CntW'(Depth));
    assign sbr_req_o = mgr_req_i && space;
    assign mgr_gnt_o = sbr_gnt_i && space;

    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;
    assign sbr_aid_o   = (ObiCfg.IdWidth == 0) ? '0 : mgr_aid_i;

    assign inc = sbr_req_o && sbr_gnt_i;
    assign dec = mgr_rvalid_o && mgr_rready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rid_in = (ObiCfg.IdWidth == 0) ? '0 : sbr_rid_i;
    assign rsp_in = {rid_in, sbr_rdata_i, sbr_err_i};

    obi_rsp_fifo #(
        .Depth (Depth),
        .Width (FifoW)
    ) u_rsp_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (sbr_rvalid_i),
        .push_data (rsp_in),
        .pop       (mgr_rready_i),
        .valid     (mgr_rvalid_o),
        .data      (rsp_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {mgr_rid_o, mgr_rdata_o, mgr_err_o} = rsp_out;

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt <= CntW'(Depth));

    a_rsp_implies_credit: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_full && fifo_empty));

endmodule

// File: tb/tb_obi_rready_converter.sv
// Bench for obi_rready_converter: directed scenarios plus randomized traffic,
// checked by a scoreboard against a transaction-level model of credits and buffering.
module tb_obi_rready_converter;
    import obi_pkg::*;

    localparam int DEPTH = 3;
    localparam obi_cfg_t CFG = '{UseRReady: 1'b1, AddrWidth: 32, DataWidth: 32, IdWidth: 4};
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int RW = IW + DW + 1;

    logic          clk;
    logic          rst;
    logic          mgr_req_i;
    logic          mgr_gnt_o;
    logic [AW-1:0] mgr_addr_i;
    logic          mgr_we_i;
    logic [3:0]    mgr_be_i;
    logic [DW-1:0] mgr_wdata_i;
    logic [IW-1:0] mgr_aid_i;
    logic          mgr_rvalid_o;
    logic          mgr_rready_i;
    logic [DW-1:0] mgr_rdata_o;
    logic [IW-1:0] mgr_rid_o;
    logic          mgr_err_o;
    logic          sbr_req_o;
    logic          sbr_gnt_i;
    logic [AW-1:0] sbr_addr_o;
    logic          sbr_we_o;
    logic [3:0]    sbr_be_o;
    logic [DW-1:0] sbr_wdata_o;
    logic [IW-1:0] sbr_aid_o;
    logic          sbr_rvalid_i;
    logic [DW-1:0] sbr_rdata_i;
    logic [IW-1:0] sbr_rid_i;
    logic          sbr_err_i;

    obi_rready_converter #(
        .ObiCfg (CFG),
        .Depth  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mgr_req_i    (mgr_req_i),
        .mgr_gnt_o    (mgr_gnt_o),
        .mgr_addr_i   (mgr_addr_i),
        .mgr_we_i     (mgr_we_i),
        .mgr_be_i     (mgr_be_i),
        .mgr_wdata_i  (mgr_wdata_i),
        .mgr_aid_i    (mgr_aid_i),
        .mgr_rvalid_o (mgr_rvalid_o),
        .mgr_rready_i (mgr_rready_i),
        .mgr_rdata_o  (mgr_rdata_o),
        .mgr_rid_o    (mgr_rid_o),
        .mgr_err_o    (mgr_err_o),
        .sbr_req_o    (sbr_req_o),
        .sbr_gnt_i    (sbr_gnt_i),
        .sbr_addr_o   (sbr_addr_o),
        .sbr_we_o     (sbr_we_o),
        .sbr_be_o     (sbr_be_o),
        .sbr_wdata_o  (sbr_wdata_o),
        .sbr_aid_o    (sbr_aid_o),
        .sbr_rvalid_i (sbr_rvalid_i),
        .sbr_rdata_i  (sbr_rdata_i),
        .sbr_rid_i    (sbr_rid_i),
        .sbr_err_i    (sbr_err_i)
    );

    // Model state: outstanding credits, beats waiting at the manager side, and
    // the in-order responses the subordinate still owes.
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] sub_q[$];
    int            due_q[$];
    logic [DW-1:0] dir_data_q[$];
    int            dir_lat = -1;
    int            cnt_m = 0;
    int            held_m = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_granted = 0;
    bit            last_hs = 0;
    bit            prev_stall = 0;
    logic [RW-1:0] prev_rsp;

    logic          m_space;
    logic          m_exp_rv;
    logic          m_a_hs;
    logic          m_r_hs;
    logic [RW-1:0] m_act;
    logic [RW-1:0] m_rsp;
    logic [DW-1:0] m_data;
    int            m_lat;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: checks each cycle's combinational outputs mid-cycle, then advances the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt_m = 0;
                held_m = 0;
                exp_q.delete();
                sub_q.delete();
                due_q.delete();
                prev_stall = 0;
                last_hs = 0;
            end else begin
                m_space = (cnt_m < DEPTH);
                check("sbr_req", 128'(sbr_req_o), 128'(mgr_req_i && m_space));
                check("mgr_gnt", 128'(mgr_gnt_o), 128'(sbr_gnt_i && m_space));
                check("a_pass_addr_wdata", 128'({sbr_addr_o, sbr_wdata_o}), 128'({mgr_addr_i, mgr_wdata_i}));
                check("a_pass_we_be_id", 128'({sbr_we_o, sbr_be_o, sbr_aid_o}), 128'({mgr_we_i, mgr_be_i, mgr_aid_i}));
                m_exp_rv = (held_m > 0) || sbr_rvalid_i;
                check("rvalid", 128'(mgr_rvalid_o), 128'(m_exp_rv));
                m_act = {mgr_rid_o, mgr_rdata_o, mgr_err_o};
                if (prev_stall) begin
                    check("rsp_stable", 128'({mgr_rvalid_o, m_act}), 128'({1'b1, prev_rsp}));
                end
                m_r_hs = m_exp_rv && mgr_rready_i;
                if (m_r_hs && exp_q.size() > 0) begin
                    check("rsp_order_id_err", 128'(m_act), 128'(exp_q.pop_front()));
                end
                prev_stall = mgr_rvalid_o && !mgr_rready_i;
                prev_rsp = m_act;
                m_a_hs = mgr_req_i && sbr_gnt_i && m_space;
                if (m_a_hs) begin
                    m_data = (dir_data_q.size() > 0) ? dir_data_q.pop_front() : DW'($urandom);
                    m_rsp = {mgr_aid_i, m_data, 1'($urandom_range(0, 1))};
                    exp_q.push_back(m_rsp);
                    sub_q.push_back(m_rsp);
                    m_lat = (dir_lat >= 0) ? dir_lat : int'($urandom_range(0, 3));
                    due_q.push_back(cyc + 1 + m_lat);
                    n_granted++;
                end
                cnt_m = cnt_m + int'(m_a_hs) - int'(m_r_hs);
                held_m = held_m + int'(sbr_rvalid_i) - int'(m_r_hs);
                last_hs = m_a_hs;
            end
            cyc++;
        end
    end

    // Subordinate: returns owed responses in order, never waiting for rready.
    initial begin
        sbr_rvalid_i = 1'b0;
        sbr_rdata_i = '0;
        sbr_rid_i = '0;
        sbr_err_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sub_q.size() > 0 && due_q[0] <= cyc) begin
                {sbr_rid_i, sbr_rdata_i, sbr_err_i} = sub_q.pop_front();
                void'(due_q.pop_front());
                sbr_rvalid_i = 1'b1;
            end else begin
                sbr_rvalid_i = 1'b0;
                sbr_rdata_i = DW'($urandom);
                sbr_rid_i = IW'($urandom_range(0, 15));
                sbr_err_i = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_payload();
        mgr_addr_i = AW'($urandom);
        mgr_we_i = 1'($urandom_range(0, 1));
        mgr_be_i = 4'($urandom_range(0, 15));
        mgr_wdata_i = DW'($urandom);
        mgr_aid_i = IW'($urandom_range(0, 15));
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    endtask

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        int start;
        rst = 1'b1;
        mgr_req_i = 1'b0;
        mgr_rready_i = 1'b0;
        sbr_gnt_i = 1'b0;
        new_payload();

        // Reset state: grant follows the subordinate, no response visible.
        #2;
        sbr_gnt_i = 1'b1;
        #1;
        check("rst_gnt_hi", 128'(mgr_gnt_o), 128'(1'b1));
        check("rst_rvalid", 128'(mgr_rvalid_o), 128'(1'b0));
        sbr_gnt_i = 1'b0;
        #1;
        check("rst_gnt_lo", 128'(mgr_gnt_o), 128'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read, response passes through on its arrival cycle.
        tick();
        dir_lat = 0;
        dir_data_q.push_back(32'hCAFE0001);
        mgr_req_i = 1'b1;
        sbr_gnt_i = 1'b1;
        mgr_rready_i = 1'b1;
        new_payload();
        tick();
        mgr_req_i = 1'b0;
        #1;
        check("t1_rvalid", 128'(mgr_rvalid_o), 128'(1'b1));
        check("t1_rdata", 128'(mgr_rdata_o), 128'(32'hCAFE0001));
        tick();
        #1;
        check("t1_idle", 128'(mgr_rvalid_o), 128'(1'b0));

        // Fill all credits with rready low, then release: ordered pops and a
        // grant that reopens only on the cycle after the first pop.
        tick();
        mgr_rready_i = 1'b0;
        mgr_req_i = 1'b1;
        new_payload();
        for (int i = 0; i < DEPTH; i++) dir_data_q.push_back(DW'(32'hA + i));
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick();
            new_payload();
        end
        tick();
        new_payload();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            check("t2_gnt_blocked", 128'(mgr_gnt_o), 128'(1'b0));
            check("t2_head", 128'({mgr_rvalid_o, mgr_rdata_o}), 128'({1'b1, 32'hA}));
        end
        tick();
        mgr_rready_i = 1'b1;
        dir_data_q.push_back(32'hD);
        #1;
        check("t4_gnt_same_cycle", 128'(mgr_gnt_o), 128'(1'b0));
        check("t2_pop_a", 128'(mgr_rdata_o), 128'(32'hA));
        tick();
        #1;
        check("t4_gnt_next_cycle", 128'(mgr_gnt_o), 128'(1'b1));
        check("t2_pop_b", 128'(mgr_rdata_o), 128'(32'hB));
        tick();
        mgr_req_i = 1'b0;
        #1;
        check("t2_pop_c", 128'({mgr_rvalid_o, mgr_rdata_o}), 128'({1'b1, 32'hC}));
        tick();
        #1;
        check("t2_pop_d", 128'({mgr_rvalid_o, mgr_rdata_o}), 128'({1'b1, 32'hD}));
        tick();
        #1;
        check("t2_empty", 128'(mgr_rvalid_o), 128'(1'b0));

        // Grant and pop in the same cycle, then push and pop on a non-empty buffer.
        tick();
        mgr_rready_i = 1'b0;
        mgr_req_i = 1'b1;
        new_payload();
        dir_data_q.push_back(32'h11);
        tick();
        mgr_req_i = 1'b0;
        tick();
        #1;
        check("t3_held", 128'({mgr_rvalid_o, mgr_rdata_o}), 128'({1'b1, 32'h11}));
        tick();
        mgr_req_i = 1'b1;
        mgr_rready_i = 1'b1;
        new_payload();
        dir_data_q.push_back(32'h22);
        #1;
        check("t3_gnt_with_pop", 128'({mgr_gnt_o, mgr_rdata_o}), 128'({1'b1, 32'h11}));
        tick();
        mgr_req_i = 1'b0;
        mgr_rready_i = 1'b0;
        #1;
        check("t3_passthru", 128'({mgr_rvalid_o, mgr_rdata_o}), 128'({1'b1, 32'h22}));
        tick();
        mgr_req_i = 1'b1;
        new_payload();
        dir_data_q.push_back(32'h33);
        tick();
        mgr_req_i = 1'b0;
        mgr_rready_i = 1'b1;
        #1;
        check("t3_push_pop", 128'(mgr_rdata_o), 128'(32'h22));
        tick();
        #1;
        check("t3_next", 128'({mgr_rvalid_o, mgr_rdata_o}), 128'({1'b1, 32'h33}));
        tick();
        #1;
        check("t3_empty", 128'(mgr_rvalid_o), 128'(1'b0));

        // Randomized traffic with random subordinate latency and rready.
        dir_lat = -1;
        start = n_granted;
        for (int k = 0; k < 3000 && n_granted < start + 20; k++) begin
            tick();
            if (!mgr_req_i || last_hs) begin
                mgr_req_i = ($urandom_range(0, 3) != 0);
                new_payload();
            end
            sbr_gnt_i = 1'($urandom_range(0, 1));
            mgr_rready_i = ($urandom_range(0, 2) == 0);
        end
        tick();
        mgr_req_i = 1'b0;
        mgr_rready_i = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
        check("t5_txn_count", 128'(n_granted >= start + 20), 128'(1'b1));
        check("t5_drained", 128'(exp_q.size()), 128'(0));

        // Reset with buffered responses drops them immediately.
        dir_lat = 0;
        sbr_gnt_i = 1'b1;
        tick();
        mgr_rready_i = 1'b0;
        mgr_req_i = 1'b1;
        new_payload();
        tick();
        new_payload();
        tick();
        mgr_req_i = 1'b0;
        repeat (2) tick();
        #1;
        check("t6_buffered", 128'(mgr_rvalid_o), 128'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        check("t6_rvalid_async", 128'(mgr_rvalid_o), 128'(1'b0));
        check("t6_gnt_in_rst", 128'(mgr_gnt_o), 128'(1'b1));
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("t6_empty_after", 128'(mgr_rvalid_o), 128'(1'b0));
        tick();
        mgr_req_i = 1'b1;
        new_payload();
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) begin
                tick();
                new_payload();
            end
            #1;
            check("t6_credit_free", 128'(mgr_gnt_o), 128'(1'b1));
        end
        tick();
        #1;
        check("t6_credit_full", 128'(mgr_gnt_o), 128'(1'b0));
        mgr_req_i = 1'b0;
        mgr_rready_i = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick();
        check("t6_drained", 128'(exp_q.size()), 128'(0));

        finish_run();
    end

endmodule
